// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit feeding the HI/LO register pair.
// Shift-add multiply and restoring divide over a fixed 34-cycle sequence.
module mult_div_unit (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic        rsign;
    logic        dsign;
    logic        bzero;
    logic [31:0] araw;
    logic [31:0] opnd;
    logic [63:0] acc;

    logic        idle;
    logic        sgn;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] msum;
    logic [32:0] trial;
    logic [63:0] acc_nx;
    logic [63:0] prod;
    logic [31:0] quo_f;
    logic [31:0] rem_f;
    logic [63:0] fix;

    assign idle = (state == IDLE) || (state == DONE);
    assign sgn  = ~op[0];

    always_comb begin
        a_mag = A;
        b_mag = B;
        if (sgn && A[31]) a_mag = ~A + 32'd1;
        if (sgn && B[31]) b_mag = ~B + 32'd1;
    end

    // acc is {partial product, multiplier} for MUL, {remainder, quotient} for DIV
    always_comb begin
        msum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
        trial = {1'b0, acc[62:31]} - {1'b0, opnd};
        if (!op_q[1])
            acc_nx = {msum, acc[31:1]};
        else if (trial[32])
            acc_nx = {acc[62:0], 1'b0};
        else
            acc_nx = {trial[31:0], acc[30:0], 1'b1};
    end

    always_comb begin
        prod  = acc;
        quo_f = acc[31:0];
        rem_f = acc[63:32];
        if (op_q == 2'b00 && rsign) prod  = ~acc + 64'd1;
        if (!op_q[0] && rsign)      quo_f = ~acc[31:0] + 32'd1;
        if (!op_q[0] && dsign)      rem_f = ~acc[63:32] + 32'd1;
        if (!op_q[1])
            fix = prod;
        else if (bzero)
            fix = {araw, 32'hFFFFFFFF};
        else
            fix = {rem_f, quo_f};
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
            op_q  <= 2'd0;
            rsign <= 1'b0;
            dsign <= 1'b0;
            bzero <= 1'b0;
            araw  <= 32'd0;
            opnd  <= 32'd0;
            acc   <= 64'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            if (idle && mthi) HI <= wdata;
            if (idle && mtlo) LO <= wdata;
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        cnt   <= 5'd0;
                        op_q  <= op;
                        rsign <= sgn & (A[31] ^ B[31]);
                        dsign <= sgn & A[31];
                        bzero <= (B == 32'd0);
                        araw  <= A;
                        opnd  <= op[1] ? b_mag : a_mag;
                        acc   <= {32'd0, (op[1] ? a_mag : b_mag)};
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    HI    <= fix[63:32];
                    LO    <= fix[31:0];
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors plus random
// operations compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;

    int compared   = 0;
    int mismatched = 0;

    mult_div_unit dut (
        .CLK   (CLK),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .HI    (HI),
        .LO    (LO),
        .busy  (busy),
        .done  (done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {HI, LO} straight from the arithmetic definition of each op
    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 64'd0;
        case (o)
            2'd0: r = sa * sb;
            2'd1: r = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFFFFFF};
                end else if (o == 2'd2) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end else begin
                    r = {a % b, a / b};
                end
            end
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit wr, input logic [31:0] wd);
        logic [63:0] exp;
        logic [63:0] hilo0;
        int          n;
        int          bc;
        bit          stable;
        exp   = model(o, a, b);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        if (wr) begin
            wdata = wd;
            mthi  = 1'b1;
            mtlo  = 1'b1;
        end
        tick();
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        if (wr) chk({tag, "/wr_hilo"}, {HI, LO}, {wd, wd});
        chk({tag, "/busy_e0"}, busy, 1);
        chk({tag, "/done_e0"}, done, 0);
        hilo0  = {HI, LO};
        bc     = busy ? 1 : 0;
        n      = 0;
        stable = 1'b1;
        while (!done && n < 50) begin
            tick();
            n++;
            if (busy) bc++;
            if (n == 5) begin
                A  = $urandom;
                B  = $urandom;
                op = 2'($urandom);
            end
            if (!done && {HI, LO} !== hilo0) stable = 1'b0;
        end
        chk({tag, "/latency"}, n, 33);
        chk({tag, "/busy_cycles"}, bc, 33);
        chk({tag, "/hilo_stable"}, stable, 1);
        chk({tag, "/busy_done"}, busy, 0);
        chk({tag, "/hilo"}, {HI, LO}, exp);
    endtask

    initial begin
        logic [31:0] lo0;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  ro;
        int          dc;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        A     = 32'd0;
        B     = 32'd0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = 32'd0;
        tick();
        tick();
        chk("reset/hilo", {HI, LO}, 64'd0);
        chk("reset/busy_done", {busy, done}, 0);
        reset = 1'b0;
        tick();

        run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        chk("multu_max/const", {HI, LO}, {32'hFFFFFFFE, 32'h00000001});
        tick();
        chk("multu_max/done_1cyc", done, 0);

        run_op("mult_neg", 2'd0, 32'hFFFFFFFD, 32'd5, 0, 0);
        chk("mult_neg/const", {HI, LO}, {32'hFFFFFFFF, 32'hFFFFFFF1});
        run_op("div_neg", 2'd2, 32'hFFFFFFF9, 32'd2, 0, 0);
        chk("div_neg/const", {HI, LO}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_op("divu", 2'd3, 32'd100, 32'd7, 0, 0);
        chk("divu/const", {HI, LO}, {32'd2, 32'd14});
        run_op("divu_zero", 2'd3, 32'd100, 32'd0, 0, 0);
        chk("divu_zero/const", {HI, LO}, {32'd100, 32'hFFFFFFFF});
        run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        chk("div_ovf/const", {HI, LO}, {32'd0, 32'h80000000});
        run_op("div_neg_zero", 2'd2, 32'hFFFFFFF9, 32'd0, 0, 0);
        tick();

        wdata = 32'h12345678;
        mthi  = 1'b1;
        tick();
        mthi  = 1'b0;
        chk("mthi_idle", HI, 32'h12345678);

        lo0   = LO;
        op    = 2'd1;
        A     = 32'd3;
        B     = 32'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        wdata = 32'hCAFEF00D;
        mtlo  = 1'b1;
        tick();
        mtlo  = 1'b0;
        chk("mtlo_busy", LO, {32'd0, lo0});
        repeat (3) tick();
        A     = 32'd9;
        B     = 32'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        dc    = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (done) dc++;
        end
        chk("start_busy/done_pulses", dc, 1);
        chk("start_busy/hilo", {HI, LO}, 64'd12);

        run_op("mthi_start", 2'd0, 32'd7, 32'hFFFFFFFE, 1, 32'hAAAA5555);

        wdata = 32'hDEADBEEF;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        tick();
        mthi  = 1'b0;
        mtlo  = 1'b0;
        chk("mthi_mtlo_both", {HI, LO}, {32'hDEADBEEF, 32'hDEADBEEF});
        op    = 2'd1;
        A     = 32'hFFFFFFFF;
        B     = 32'hFFFFFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        #1;
        chk("abort/hilo", {HI, LO}, 64'd0);
        chk("abort/busy_done", {busy, done}, 0);
        tick();
        reset = 1'b0;
        tick();
        run_op("after_abort", 2'd1, 32'd6, 32'd7, 0, 0);
        chk("after_abort/const", {HI, LO}, 64'd42);

        for (int k = 0; k < 40; k++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin
                    ra = 32'h80000000;
                    rb = 32'hFFFFFFFF;
                end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'($urandom_range(0, 255));
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) tick();
            run_op("random", ro, ra, rb, 0, 0);
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
